// File: rtl/fetch_unit.sv
// fetch_unit: owns the fetch PC, issues imem req/ack reads, queues instructions and handles redirects.
// Build option FETCH_STATS_EN adds stat_fetched/stat_discarded counter outputs.
module fetch_unit #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          QUEUE_DEPTH = 2
) (
   input  logic        clock,
   input  logic        reset_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_data,
`ifdef FETCH_STATS_EN
   output logic [31:0] stat_fetched,
   output logic [31:0] stat_discarded,
`endif
   output logic [31:0] inst_pc
);
   localparam int PW = $clog2(QUEUE_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(QUEUE_DEPTH);

   typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

   state_t         state_q, state_d;
   logic           req_q, req_d;
   logic [31:0]    addr_q, addr_d;
   logic [31:0]    tgt_q, tgt_d;
   logic [PW-1:0]  rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [31:0]    qdata_q [QUEUE_DEPTH];
   logic [31:0]    qdata_d [QUEUE_DEPTH];
   logic [31:0]    qpc_q [QUEUE_DEPTH];
   logic [31:0]    qpc_d [QUEUE_DEPTH];
   logic           ack, pop, push, stall;
   logic [31:0]    redir_pc;

   assign ack      = req_q && imem_ack;
   assign pop      = cnt_q != '0 && inst_ready;
   assign push     = state_q == REQ && ack && !redirect_valid;
   assign stall    = state_q == REQ && !ack;
   assign redir_pc = redirect_pc & ~32'h3;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      tgt_d   = tgt_q;
      rd_d    = pop ? rd_q + PW'(1) : rd_q;
      wr_d    = push ? wr_q + PW'(1) : wr_q;
      cnt_d   = cnt_q + CW'(push) - CW'(pop);
      qdata_d = qdata_q;
      qpc_d   = qpc_q;
      if (push) begin
         qdata_d[wr_q] = imem_rdata;
         qpc_d[wr_q]   = addr_q;
      end
      if (redirect_valid) begin
         rd_d  = '0;
         wr_d  = '0;
         cnt_d = '0;
      end
      // An outstanding request must complete before the new target can be issued
      if (state_q == DRAIN) begin
         tgt_d = redirect_valid ? redir_pc : tgt_q;
         if (ack) begin
            state_d = REQ;
            addr_d  = tgt_d;
         end
      end else if (redirect_valid) begin
         state_d = stall ? DRAIN : REQ;
         tgt_d   = redir_pc;
         addr_d  = stall ? addr_q : redir_pc;
      end else if (state_q == IDLE) begin
         state_d = cnt_q < FULL ? REQ : IDLE;
      end else if (ack) begin
         addr_d  = addr_q + 32'd4;
         state_d = cnt_d < FULL ? REQ : IDLE;
      end
      req_d = state_d != IDLE;
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
         addr_q  <= RESET_PC;
         tgt_q   <= RESET_PC;
         rd_q    <= '0;
         wr_q    <= '0;
         cnt_q   <= '0;
         qdata_q <= '{default: '0};
         qpc_q   <= '{default: '0};
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         addr_q  <= addr_d;
         tgt_q   <= tgt_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         cnt_q   <= cnt_d;
         qdata_q <= qdata_d;
         qpc_q   <= qpc_d;
      end
   end

   assign imem_req   = req_q;
   assign imem_addr  = addr_q;
   assign inst_valid = cnt_q != '0;
   assign inst_data  = inst_valid ? qdata_q[rd_q] : '0;
   assign inst_pc    = inst_valid ? qpc_q[rd_q] : '0;

`ifdef FETCH_STATS_EN
   logic [31:0] fetched_q, fetched_d, discarded_q, discarded_d;

   // Flushed entries exclude one popped in the same cycle, which the core accepted
   always_comb begin
      fetched_d   = fetched_q + 32'(push);
      discarded_d = discarded_q + 32'(ack && !push) +
                    (redirect_valid ? 32'(cnt_q - CW'(pop)) : 32'd0);
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         fetched_q   <= '0;
         discarded_q <= '0;
      end else begin
         fetched_q   <= fetched_d;
         discarded_q <= discarded_d;
      end
   end

   assign stat_fetched   = fetched_q;
   assign stat_discarded = discarded_q;
`endif
endmodule
